// File: rtl/freq_cal_ctrl.sv
// freq_cal_ctrl: SAR trim search that measures a ring oscillator against a target edge count.
// Each trim bit is settled, measured and decided, then a final measurement decides lock.
module freq_cal_ctrl #(
    parameter int TRIM_W = 5,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  target_count,
    input  logic [CNT_W-1:0]  tolerance,
    input  logic [CNT_W-1:0]  window_cycles,
    input  logic              ro_clk,
    output logic              en_ro,
    output logic [TRIM_W-1:0] trim,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic [CNT_W-1:0]  measured_count
);
    localparam int BW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DECIDE, ST_DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         ro_sync;
    logic [CNT_W-1:0]   tmr, cnt, cnt_nx, tgt, tol, win;
    logic [BW-1:0]      bidx;
    logic               final_pass, rise, settle_end, meas_end, lock_ok;
    logic [TRIM_W-1:0]  trim_dec;
    logic [CNT_W:0]     diff;

    // ro_sync[1] is the synchronised tap, ro_sync[2] its previous value
    assign rise       = ro_sync[1] & ~ro_sync[2];
    assign cnt_nx     = (rise && !(&cnt)) ? cnt + 1'b1 : cnt;
    assign settle_end = tmr == CNT_W'(SETTLE - 1);
    assign meas_end   = tmr == win - 1'b1;
    assign diff       = (measured_count >= tgt) ? {1'b0, measured_count} - {1'b0, tgt}
                                                : {1'b0, tgt} - {1'b0, measured_count};
    assign lock_ok    = diff <= {1'b0, tol};
    assign busy       = state == ST_SETTLE || state == ST_MEASURE || state == ST_DECIDE;
    assign done       = state == ST_DONE;

    always_comb begin
        trim_dec = trim;
        if (measured_count > tgt)
            trim_dec[bidx] = 1'b0;
        if (bidx != '0)
            trim_dec[bidx - 1'b1] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = (start && !abort) ? ST_SETTLE : ST_IDLE;
            ST_SETTLE:  state_nx = settle_end ? ST_MEASURE : ST_SETTLE;
            ST_MEASURE: state_nx = meas_end ? ST_DECIDE : ST_MEASURE;
            ST_DECIDE:  state_nx = final_pass ? ST_DONE : ST_SETTLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_sync        <= '0;
            tmr            <= '0;
            cnt            <= '0;
            tgt            <= '0;
            tol            <= '0;
            win            <= '0;
            bidx           <= '0;
            final_pass     <= 1'b0;
            en_ro          <= 1'b0;
            trim           <= '0;
            locked         <= 1'b0;
            measured_count <= '0;
        end else begin
            ro_sync <= {ro_sync[1:0], ro_clk};
            tmr     <= (state_nx != state) ? '0 : tmr + 1'b1;
            cnt     <= (state == ST_MEASURE) ? cnt_nx : '0;
            if (state == ST_IDLE && state_nx == ST_SETTLE) begin
                tgt        <= target_count;
                tol        <= tolerance;
                win        <= (window_cycles == '0) ? CNT_W'(1) : window_cycles;
                trim       <= TRIM_W'(1) << (TRIM_W - 1);
                bidx       <= BW'(TRIM_W - 1);
                final_pass <= 1'b0;
                en_ro      <= 1'b1;
                locked     <= 1'b0;
            end
            if (state == ST_MEASURE && state_nx == ST_DECIDE)
                measured_count <= cnt_nx;
            if (state == ST_DECIDE && state_nx != ST_IDLE) begin
                if (final_pass)
                    locked <= lock_ok;
                else begin
                    trim <= trim_dec;
                    if (bidx == '0)
                        final_pass <= 1'b1;
                    else
                        bidx <= bidx - 1'b1;
                end
            end
            if (abort && state != ST_IDLE)
                locked <= 1'b0;
        end
    end
endmodule

// File: tb/tb_freq_cal_ctrl.sv
// tb_freq_cal_ctrl: directed checks of the trim search against a trim-controlled oscillator model.
module tb_freq_cal_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] target_count = '0;
    logic [15:0] tolerance = '0;
    logic [15:0] window_cycles = '0;
    logic        ro_clk = 1'b0;
    logic        en_ro, busy, done, locked;
    logic [4:0]  trim;
    logic [15:0] measured_count;
    logic        fast = 1'b0;
    int          vecs = 0;
    int          miscompares = 0;
    int          dones = 0;
    int          n, d0;

    freq_cal_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_count(target_count), .tolerance(tolerance), .window_cycles(window_cycles),
        .ro_clk(ro_clk), .en_ro(en_ro), .trim(trim), .busy(busy), .done(done),
        .locked(locked), .measured_count(measured_count)
    );

    initial forever #5 clk = ~clk;

    // Oscillator: half period of (33 - trim) clk cycles, or toggling every cycle when fast
    initial begin
        int oc = 0;
        forever begin
            @(negedge clk);
            if (fast)
                ro_clk = ~ro_clk;
            else begin
                oc++;
                if (oc >= 33 - int'(trim)) begin
                    ro_clk = ~ro_clk;
                    oc = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1)
            dones++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (done !== 1'b1 && cnt < limit);
        chk("done_seen", 32'(done), 1);
    endtask

    initial begin
        #23;
        chk("rst_en_ro", 32'(en_ro), 0);
        chk("rst_trim", 32'(trim), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_measured", 32'(measured_count), 0);
        rst_n = 1'b1;
        step();
        step();

        // Nominal lock, with a second start (new target) ignored mid-run
        target_count = 40;
        tolerance = 1;
        window_cycles = 1024;
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        chk("trim_first_trial", 32'(trim), 16);
        chk("en_ro_on", 32'(en_ro), 1);
        repeat (99) step();
        target_count = 5;
        pulse_start();
        wait_done(8000, n);
        chk("nominal_latency", 32'(n + 100), 6246);
        chk("nominal_trim", 32'(trim), 20);
        chk("nominal_locked", 32'(locked), 1);
        chk("nominal_count_39_40", 32'(measured_count == 39 || measured_count == 40), 1);
        chk("done_busy_low", 32'(busy), 0);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("post_done_trim", 32'(trim), 20);
        chk("post_done_en_ro", 32'(en_ro), 1);
        chk("post_done_locked", 32'(locked), 1);

        // Out of range: oscillator too fast even at trim 0
        pulse_start();
        wait_done(8000, n);
        chk("oor_latency", 32'(n), 6246);
        chk("oor_trim", 32'(trim), 0);
        chk("oor_locked", 32'(locked), 0);
        chk("oor_count_15_16", 32'(measured_count == 15 || measured_count == 16), 1);
        step();

        // Maximum rate with all-ones target
        fast = 1'b1;
        target_count = 16'hffff;
        pulse_start();
        wait_done(8000, n);
        chk("fast_trim", 32'(trim), 31);
        chk("fast_count", 32'(measured_count), 512);
        chk("fast_locked", 32'(locked), 0);
        step();

        // Zero window behaves as a one-cycle window
        fast = 1'b0;
        target_count = 40;
        window_cycles = 0;
        pulse_start();
        wait_done(1000, n);
        chk("win0_latency", 32'(n), 108);
        step();

        // Abort a few cycles into the second measurement window
        window_cycles = 1024;
        d0 = dones;
        pulse_start();
        repeat (1059) step();
        chk("pre_abort_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_trim", 32'(trim), 24);
        chk("abort_en_ro", 32'(en_ro), 1);
        chk("abort_locked", 32'(locked), 0);
        repeat (40) step();
        chk("abort_no_done", 32'(dones - d0), 0);
        chk("abort_stays_idle", 32'(busy), 0);
        chk("abort_count_first_pass", 32'(measured_count == 30 || measured_count == 31), 1);

        // start and abort together in idle do nothing
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of SETTLE
        d0 = dones;
        pulse_start();
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en_ro", 32'(en_ro), 0);
        chk("mid_rst_trim", 32'(trim), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_measured", 32'(measured_count), 0);
        step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("mid_rst_no_done", 32'(dones - d0), 0);
        pulse_start();
        chk("restart_busy", 32'(busy), 1);
        chk("restart_trim", 32'(trim), 16);
        chk("restart_en_ro", 32'(en_ro), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
